// File: rtl/taptempo_pkg.sv
// Shared tap-tempo definitions, used by tap_period and by per2bpm so that both
// sides agree on the width of the measured period.
//   MIN_NS_DEF  : nanoseconds per minute (default for MIN_NS)
//   per_max()   : largest period in ticks, MIN_NS / TP_CYCLE
//   per_size()  : bits needed to hold 0..per_max()
//   tap_state_e : tap measurement FSM states
package taptempo_pkg;

  localparam longint unsigned MIN_NS_DEF = 64'd60_000_000_000;

  typedef enum logic [0:0] {StIdle, StCount} tap_state_e;

  function automatic int unsigned per_max(input longint unsigned tp_cycle,
                                          input longint unsigned min_ns = MIN_NS_DEF);
    longint unsigned q;
    q = min_ns / tp_cycle;
    return q[31:0];
  endfunction

  function automatic int unsigned per_size(input longint unsigned tp_cycle,
                                           input longint unsigned min_ns = MIN_NS_DEF);
    return $clog2(64'(per_max(tp_cycle, min_ns)) + 64'd1);
  endfunction

endpackage

// File: rtl/tap_period_if.sv
// Button-in / period-out bundle of tap_period.
//   btn_i         : debounced button level, 1 = pressed
//   btn_per_o     : measured tap period in ticks
//   btn_per_valid : 1-cycle strobe qualifying btn_per_o
//   armed_o       : high while a measurement is in progress
// Modports: master = button side / consumer, slave = tap_period.
interface tap_period_if
  import taptempo_pkg::*;
#(
  parameter int unsigned BTN_PER_SIZE = per_size(64'd5120, MIN_NS_DEF)
);
  logic                    btn_i;
  logic [BTN_PER_SIZE-1:0] btn_per_o;
  logic                    btn_per_valid;
  logic                    armed_o;

  modport master (output btn_i, input btn_per_o, input btn_per_valid, input armed_o);
  modport slave  (input btn_i, output btn_per_o, output btn_per_valid, output armed_o);
endinterface

// File: rtl/timepulse.sv
// Clock prescaler: counts 0..TP_DIV-1 and flags the last count as a tick.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active low
//   clr_i  : restart the count at 0 (phase alignment)
//   tick_o : high for one cycle every TP_DIV cycles
module timepulse #(
  parameter int unsigned TP_DIV = 128
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CW = (TP_DIV > 1) ? $clog2(TP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TP_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick_o = (r_cnt == LAST);
endmodule

// File: rtl/tap_period.sv
// Measures the interval between consecutive taps of the tempo button in
// timepulse ticks (TP_CYCLE ns each) and strobes it out for one cycle.
//   clk_i  : system clock (CLK_PER_NS period)
//   rst_ni : asynchronous reset, active low
//   bus    : tap_period_if.slave (btn_i in; btn_per_o, btn_per_valid, armed_o out)
// Optional build macro TAP_AVG4_EN: output the floor mean of the last four
// periods instead of the raw period, with one extra cycle of latency.
module tap_period
  import taptempo_pkg::*;
#(
  parameter int unsigned     CLK_PER_NS = 40,
  parameter int unsigned     TP_CYCLE   = 5120,
  parameter longint unsigned MIN_NS     = MIN_NS_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  tap_period_if.slave  bus
);
  localparam int unsigned TP_DIV       = TP_CYCLE / CLK_PER_NS;
  localparam int unsigned BTN_PER_MAX  = per_max(64'(TP_CYCLE), MIN_NS);
  localparam int unsigned BTN_PER_SIZE = per_size(64'(TP_CYCLE), MIN_NS);
  localparam logic [BTN_PER_SIZE-1:0] MAX_V = BTN_PER_SIZE'(BTN_PER_MAX);

  tap_state_e              r_state, w_state_d;
  logic                    r_btn;
  logic [BTN_PER_SIZE-1:0] r_ticks, w_ticks_d;
  logic                    w_tap, w_tick, w_meas;
  logic [BTN_PER_SIZE-1:0] w_per;
  logic                    r_valid;

  assign w_tap = bus.btn_i & ~r_btn;

  // Prescaler restarts on every tap so each period starts at tick phase 0.
  timepulse #(
    .TP_DIV(TP_DIV)
  ) u_timepulse (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (w_tap),
    .tick_o(w_tick)
  );

  always_comb begin
    w_state_d = r_state;
    w_ticks_d = r_ticks;
    w_meas    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_tap) begin
          w_state_d = StCount;
          w_ticks_d = '0;
        end
      end
      StCount: begin
        // A tap beats a coincident tick or timeout.
        if (w_tap) begin
          w_meas    = 1'b1;
          w_ticks_d = '0;
        end else if (w_tick) begin
          if (r_ticks == MAX_V) begin
            w_state_d = StIdle;
          end else begin
            w_ticks_d = r_ticks + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_btn   <= 1'b0;
      r_ticks <= '0;
    end else begin
      r_state <= w_state_d;
      r_btn   <= bus.btn_i;
      r_ticks <= w_ticks_d;
    end
  end

`ifdef TAP_AVG4_EN
  localparam int unsigned SW = BTN_PER_SIZE + 2;

  logic [BTN_PER_SIZE-1:0] r_hist [4];
  logic                    r_first;
  logic                    r_hvld;
  logic [SW-1:0]           r_sum;
  logic [SW-1:0]           w_sum;
  logic                    w_timeout;

  assign w_timeout = (r_state == StCount) && (w_state_d == StIdle);
  assign w_sum = SW'(r_hist[0]) + SW'(r_hist[1]) + SW'(r_hist[2]) + SW'(r_hist[3]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_first <= 1'b0;
      r_hvld  <= 1'b0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_hvld  <= w_meas;
      r_valid <= r_hvld;
      if ((r_state == StIdle) && w_tap) begin
        r_first <= 1'b1;
      end else if (w_meas) begin
        r_first <= 1'b0;
      end
      if (w_meas) begin
        // First period of a run seeds every slot so the mean equals it.
        if (r_first) begin
          for (int i = 0; i < 4; i++) r_hist[i] <= r_ticks;
        end else begin
          r_hist[0] <= r_ticks;
          r_hist[1] <= r_hist[0];
          r_hist[2] <= r_hist[1];
          r_hist[3] <= r_hist[2];
        end
      end else if (w_timeout) begin
        for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      end
      if (r_hvld) begin
        r_sum <= w_sum;
      end
    end
  end

  assign w_per = r_sum[SW-1:2];
`else
  logic [BTN_PER_SIZE-1:0] r_per;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_per   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_meas;
      if (w_meas) begin
        r_per <= r_ticks;
      end
    end
  end

  assign w_per = r_per;
`endif

  assign bus.btn_per_o     = w_per;
  assign bus.btn_per_valid = r_valid;
  assign bus.armed_o       = (r_state == StCount);
endmodule
